sort_stream_checker: RTL

//  Receive-side monitor for the merge-sorter stream interface: taps the unsorted

---
 rtl/sort_stream_checker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sort_stream_checker.sv
// Receive-side checker for the merge-sorter stream: verifies length, order and sum per frame.
// Optional capture RAM of the sorted frame enabled with `define SORTCHK_CAPTURE_EN.
//
// state  | meaning
// S_IDLE | waiting for first input beat, previous verdict held
// S_IN   | accumulating input frame
// S_OUT  | accumulating sorted output frame, checking order
// S_DONE | verdict cycle (done=1), accumulators cleared
module sort_stream_checker #(
  parameter int DATA_W = 8,
  parameter int N      = 32,
  parameter int CNT_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [DATA_W-1:0]    out_data,
  input  logic                 out_valid,
  input  logic                 out_last,
`ifdef SORTCHK_CAPTURE_EN
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data,
`endif
  output logic                 done,
  output logic                 pass,
  output logic                 err_order,
  output logic                 err_len,
  output logic                 err_sum,
  output logic                 err_proto,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int AW    = $clog2(N);
  localparam int SUM_W = DATA_W + AW + 1;
  localparam int BC_W  = AW + 2;
  localparam logic [BC_W-1:0] BC_N   = BC_W'(N);
  localparam logic [BC_W-1:0] BC_SAT = BC_W'(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    in_sum_q, in_sum_d;
  logic [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic [BC_W-1:0]     in_cnt_q, in_cnt_d;
  logic [BC_W-1:0]     out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                pass_q, pass_d;
  logic                err_order_q, err_order_d;
  logic                err_len_q, err_len_d;
  logic                err_sum_q, err_sum_d;
  logic                err_proto_q, err_proto_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  logic [BC_W-1:0]     in_cnt_inc, out_cnt_inc;
  logic [SUM_W-1:0]    in_sum_add, out_sum_add;
  logic                len_bad, sum_bad;

  // Beat counters stick at N+1 so an over-long frame can never alias to a legal length.
  always_comb begin
    in_cnt_inc  = (in_cnt_q == BC_SAT) ? in_cnt_q : in_cnt_q + BC_W'(1);
    out_cnt_inc = (out_cnt_q == BC_SAT) ? out_cnt_q : out_cnt_q + BC_W'(1);
    in_sum_add  = in_sum_q + SUM_W'(in_data);
    out_sum_add = out_sum_q + SUM_W'(out_data);
  end

  always_comb begin
    state_d     = state_q;
    in_sum_d    = in_sum_q;
    out_sum_d   = out_sum_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    prev_d      = prev_q;
    pass_d      = pass_q;
    err_order_d = err_order_q;
    err_len_d   = err_len_q;
    err_sum_d   = err_sum_q;
    err_proto_d = err_proto_q;
    frame_cnt_d = frame_cnt_q;
    len_bad     = 1'b0;
    sum_bad     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pass_d      = 1'b0;
          err_order_d = 1'b0;
          err_len_d   = 1'b0;
          err_sum_d   = 1'b0;
          err_proto_d = 1'b0;
          in_cnt_d    = BC_W'(1);
          in_sum_d    = SUM_W'(in_data);
          state_d     = in_last ? S_OUT : S_IN;
        end
      end

      S_IN: begin
        if (out_valid) err_proto_d = 1'b1;
        if (in_valid) begin
          in_cnt_d = in_cnt_inc;
          in_sum_d = in_sum_add;
          if (in_last) state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (in_valid) err_proto_d = 1'b1;
        if (out_valid) begin
          out_cnt_d = out_cnt_inc;
          out_sum_d = out_sum_add;
          prev_d    = out_data;
          if ((out_cnt_q != '0) && (out_data < prev_q)) err_order_d = 1'b1;
          // Verdict is resolved on the closing beat so it is stable while done is high.
          if (out_last) begin
            len_bad     = (in_cnt_q != out_cnt_inc) || (in_cnt_q == '0) ||
                          (in_cnt_q > BC_N) || (out_cnt_inc > BC_N);
            sum_bad     = (in_sum_q != out_sum_add);
            err_len_d   = len_bad;
            err_sum_d   = sum_bad;
            pass_d      = !(len_bad || sum_bad || err_order_d || err_proto_d);
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = S_DONE;
          end
        end
      end

      S_DONE: begin
        in_sum_d  = '0;
        out_sum_d = '0;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        prev_d    = '0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_sum_q    <= '0;
      out_sum_q   <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      prev_q      <= '0;
      pass_q      <= 1'b0;
      err_order_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_sum_q   <= 1'b0;
      err_proto_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_sum_q    <= in_sum_d;
      out_sum_q   <= out_sum_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      prev_q      <= prev_d;
      pass_q      <= pass_d;
      err_order_q <= err_order_d;
      err_len_q   <= err_len_d;
      err_sum_q   <= err_sum_d;
      err_proto_q <= err_proto_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_order = err_order_q;
  assign err_len   = err_len_q;
  assign err_sum   = err_sum_q;
  assign err_proto = err_proto_q;
  assign frame_cnt = frame_cnt_q;

`ifdef SORTCHK_CAPTURE_EN
  // Capture RAM keeps its contents through reset so a frame can be inspected after a fault.
  logic [DATA_W-1:0] cap_mem [N];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              cap_we;

  always_comb begin
    cap_we    = (state_q == S_OUT) && out_valid && (out_cnt_q < BC_N);
    rd_data_d = cap_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (cap_we) cap_mem[out_cnt_q[AW-1:0]] <= out_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule
